// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic datapath.
// Contents: digit width and maximum digit value, the serial subtractor's
// state type, a digit validity check and a single-digit subtract with borrow.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // True when the nibble encodes a decimal digit (0..9).
    function automatic logic digit_valid(input logic [DIGIT_W-1:0] nibble);
        return nibble <= DIGIT_W'(BCD_MAX);
    endfunction

    // Returns {borrow_out, digit} for a - b - borrow.
    // For out-of-range nibbles the digit is meaningless; callers mask it.
    function automatic logic [DIGIT_W:0] digit_sub(input logic [DIGIT_W-1:0] a,
                                                   input logic [DIGIT_W-1:0] b,
                                                   input logic               borrow);
        logic signed [DIGIT_W:0] t;
        logic signed [DIGIT_W:0] u;
        t = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({{DIGIT_W{1'b0}}, borrow});
        u = t + 5'sd10;
        if (t < 0) begin
            return {1'b1, u[DIGIT_W-1:0]};
        end
        return {1'b0, t[DIGIT_W-1:0]};
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit subtract with borrow.
// Ports:
//   a_i      minuend digit
//   b_i      subtrahend digit
//   borrow_i borrow in
//   diff_o   result digit (ten's complement corrected when negative)
//   borrow_o borrow out
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    input  logic               borrow_i,
    output logic [DIGIT_W-1:0] diff_o,
    output logic               borrow_o
);

    logic [DIGIT_W:0] res;

    always_comb begin
        res      = digit_sub(a_i, b_i, borrow_i);
        diff_o   = res[DIGIT_W-1:0];
        borrow_o = res[DIGIT_W];
    end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per
// clock, least significant digit first, ten's complement on underflow.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   start_i   request, sampled only when idle
//   a_i, b_i  minuend / subtrahend, packed BCD (digit 0 in [3:0])
//   bin_i     borrow in
//   busy_o    operation in progress
//   done_o    one-cycle pulse, result valid
//   diff_o    difference, packed BCD
//   bout_o    borrow out (a < b + bin)
//   invalid_o an operand digit exceeded 9; diff/bout forced to 0
module bcd_subtractor_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [DIGITS*DIGIT_W-1:0]   a_i,
    input  logic [DIGITS*DIGIT_W-1:0]   b_i,
    input  logic                        bin_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [DIGITS*DIGIT_W-1:0]   diff_o,
    output logic                        bout_o,
    output logic                        invalid_o
);

    localparam int unsigned W    = DIGITS * DIGIT_W;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [W-1:0]      a_q, b_q, work_q;
    logic              borrow_q;
    logic              inv_q;
    logic              busy_q, done_q, bout_q, invalid_q;
    logic [W-1:0]      diff_q;

    logic [DIGIT_W-1:0] a_dig, b_dig, d_dig;
    logic               d_borrow;
    logic [W-1:0]       work_d;
    logic               ops_invalid;
    logic               last_digit;

    always_comb begin
        a_dig = a_q[idx_q*DIGIT_W +: DIGIT_W];
        b_dig = b_q[idx_q*DIGIT_W +: DIGIT_W];
    end

    bcd_digit_sub u_digit_sub (
        .a_i      (a_dig),
        .b_i      (b_dig),
        .borrow_i (borrow_q),
        .diff_o   (d_dig),
        .borrow_o (d_borrow)
    );

    always_comb begin
        work_d = work_q;
        work_d[idx_q*DIGIT_W +: DIGIT_W] = d_dig;
        last_digit = (idx_q == IdxW'(DIGITS - 1));
    end

    // Operand check on the live inputs, captured at the accept edge.
    always_comb begin
        ops_invalid = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!digit_valid(a_i[i*DIGIT_W +: DIGIT_W]) ||
                !digit_valid(b_i[i*DIGIT_W +: DIGIT_W])) begin
                ops_invalid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            borrow_q  <= 1'b0;
            inv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q       <= a_i;
                        b_q       <= b_i;
                        borrow_q  <= bin_i;
                        work_q    <= '0;
                        idx_q     <= '0;
                        inv_q     <= ops_invalid;
                        busy_q    <= 1'b1;
                        diff_q    <= '0;
                        bout_q    <= 1'b0;
                        invalid_q <= 1'b0;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    work_q   <= work_d;
                    borrow_q <= d_borrow;
                    idx_q    <= idx_q + IdxW'(1);
                    if (last_digit) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (inv_q) begin
                            diff_q    <= '0;
                            bout_q    <= 1'b0;
                            invalid_q <= 1'b1;
                        end else begin
                            diff_q    <= work_d;
                            bout_q    <= d_borrow;
                            invalid_q <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign diff_o    = diff_q;
    assign bout_o    = bout_q;
    assign invalid_o = invalid_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial: directed cases plus
// randomized operands checked against a decimal-arithmetic reference model.
module tb_bcd_subtractor_serial;

    localparam int unsigned DIGITS = 3;
    localparam int unsigned W      = DIGITS * 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] a_i, b_i;
    logic         bin_i;
    logic         busy_o, done_o, bout_o, invalid_o;
    logic [W-1:0] diff_o;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .bin_i     (bin_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .diff_o    (diff_o),
        .bout_o    (bout_o),
        .invalid_o (invalid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: operands as decimal integers, plain subtraction, wrap by 10^DIGITS.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] diff, output logic bout, output logic inv);
        int av, bv, d, modulus;
        logic [3:0] na, nb;
        av = 0; bv = 0; inv = 1'b0; modulus = 1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            na = a[i*4 +: 4];
            nb = b[i*4 +: 4];
            if (na > 4'd9 || nb > 4'd9) inv = 1'b1;
            av = av * 10 + int'(na);
            bv = bv * 10 + int'(nb);
            modulus = modulus * 10;
        end
        d = av - bv - int'(bin);
        bout = (d < 0);
        if (d < 0) d = d + modulus;
        diff = '0;
        for (int i = 0; i < DIGITS; i++) begin
            diff[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        if (inv) begin
            diff = '0;
            bout = 1'b0;
        end
    endtask

    // Called #1 after a posedge with the DUT idle. When disturb is set, start
    // stays high and a changes for two cycles after the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit disturb, input string tag);
        logic [W-1:0] ediff;
        logic         ebout, einv;
        int           lat, busy_cnt, done_cnt;
        model(a, b, bin, ediff, ebout, einv);
        a_i = a; b_i = b; bin_i = bin; start_i = 1'b1;
        @(posedge clk_i); #1;
        check_value({tag, "_busy_at_accept"}, 32'(busy_o), 32'd1);
        check_value({tag, "_diff_cleared"}, 32'(diff_o), 32'd0);
        busy_cnt = 1; lat = 0; done_cnt = 0;
        if (disturb) a_i = W'($urandom);
        else start_i = 1'b0;
        for (int n = 1; n <= int'(DIGITS) + 4; n++) begin
            @(posedge clk_i); #1;
            if (disturb && n == 1) a_i = W'($urandom);
            if (n == 2) start_i = 1'b0;
            if (done_o) begin
                lat = n;
                done_cnt++;
                break;
            end
            if (busy_o) busy_cnt++;
        end
        if (lat == 0) begin
            check_value({tag, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_value({tag, "_latency"}, 32'(lat), 32'(DIGITS));
        check_value({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DIGITS));
        check_value({tag, "_busy_in_done"}, 32'(busy_o), 32'd0);
        check_value({tag, "_diff"}, 32'(diff_o), 32'(ediff));
        check_value({tag, "_bout"}, 32'(bout_o), 32'(ebout));
        check_value({tag, "_invalid"}, 32'(invalid_o), 32'(einv));
        // Pulse must drop and results must hold while idle.
        for (int n = 0; n < 2; n++) begin
            a_i = W'($urandom);
            @(posedge clk_i); #1;
            if (done_o) done_cnt++;
        end
        check_value({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check_value({tag, "_hold_diff"}, 32'(diff_o), 32'(ediff));
        check_value({tag, "_hold_bout"}, 32'(bout_o), 32'(ebout));
        check_value({tag, "_hold_invalid"}, 32'(invalid_o), 32'(einv));
    endtask

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && $urandom_range(7, 0) == 0) v[i*4 +: 4] = 4'($urandom_range(15, 10));
            else v[i*4 +: 4] = 4'($urandom_range(9, 0));
        end
        return v;
    endfunction

    initial begin
        int done_seen;
        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_value("reset_busy", 32'(busy_o), 32'd0);
        check_value("reset_done", 32'(done_o), 32'd0);
        check_value("reset_diff", 32'(diff_o), 32'd0);
        check_value("reset_bout", 32'(bout_o), 32'd0);
        check_value("reset_invalid", 32'(invalid_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_op(12'h499, 12'h490, 1'b0, 1'b0, "simple");
        check_value("simple_exact", 32'(diff_o), 32'h009);
        run_op(12'h100, 12'h001, 1'b0, 1'b0, "ripple");
        check_value("ripple_exact", 32'(diff_o), 32'h099);
        run_op(12'h000, 12'h001, 1'b0, 1'b0, "wrap");
        check_value("wrap_exact", 32'({bout_o, diff_o}), 32'h1999);
        run_op(12'h075, 12'h075, 1'b1, 1'b0, "eq_bin");
        check_value("eq_bin_exact", 32'({bout_o, diff_o}), 32'h1999);
        run_op(12'h0A5, 12'h001, 1'b0, 1'b0, "invalid");
        check_value("invalid_exact", 32'(invalid_o), 32'd1);
        run_op(12'h009, 12'h004, 1'b0, 1'b0, "after_inv");
        check_value("after_inv_exact", 32'({invalid_o, diff_o}), 32'h005);
        run_op(12'h500, 12'h123, 1'b0, 1'b1, "disturb");
        check_value("disturb_exact", 32'(diff_o), 32'h377);

        // Abort: reset during the second RUN cycle.
        a_i = 12'h321; b_i = 12'h123; bin_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_value("abort_busy", 32'(busy_o), 32'd0);
        check_value("abort_diff", 32'(diff_o), 32'd0);
        done_seen = 0;
        for (int n = 0; n < 6; n++) begin
            if (done_o) done_seen++;
            @(posedge clk_i); #1;
        end
        check_value("abort_no_done", 32'(done_seen), 32'd0);
        run_op(12'h050, 12'h049, 1'b0, 1'b0, "post_abort");
        check_value("post_abort_exact", 32'(diff_o), 32'h001);

        for (int k = 0; k < 40; k++) begin
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(1, 0)), k % 7 == 3,
                   "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

endmodule
